// File: rtl/reg_file.sv
// ----------------------------------------------------------------------------
// reg_file : general-purpose register file for the single-cycle MIPS datapath.
//
// DEPTH = 2**ADDR_W entries of WIDTH bits. Entry 0 is hardwired to zero:
// writes to it are dropped and every read of address 0 returns 0.
// Two combinational read ports feed the ALU operands and one combinational
// debug port observes storage. One synchronous write port commits the
// write-back value on the rising clock edge.
//
// Optional feature (macro RF_BYPASS_EN):
//   When defined, rd1/rd2 forward wd in the same cycle when we=1, wa!=0 and
//   the read address matches wa (write-first). dbg_data is never bypassed,
//   and the bypass is suppressed while rst_n is low.
//   When undefined, reads always return the stored (pre-edge) contents.
//
// Ports:
//   clk       in   system clock, writes on rising edge
//   rst_n     in   asynchronous active-low reset, clears every entry
//   we        in   write enable (RegWrite)
//   wa        in   write address (destination-select mux)
//   wd        in   write data (write-back mux)
//   ra1, ra2  in   read addresses (rs, rt)
//   rd1, rd2  out  read data
//   dbg_addr  in   debug read address
//   dbg_data  out  debug read data (stored contents only)
// ----------------------------------------------------------------------------
module reg_file #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [WIDTH-1:0]  wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [WIDTH-1:0]  rd1,
    output logic [WIDTH-1:0]  rd2,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [WIDTH-1:0]  dbg_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_hit;

    // A write only takes effect for a non-zero destination.
    assign wr_hit = we && (wa != '0);

    // Reset wins over any write on the same edge. Entry 0 is cleared by
    // reset and never written, so it stays zero in storage as well.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_hit) begin
            mem[wa] <= wd;
        end
    end

    always_comb begin
        rd1      = (ra1 == '0)      ? '0 : mem[ra1];
        rd2      = (ra2 == '0)      ? '0 : mem[ra2];
        dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];
`ifdef RF_BYPASS_EN
        // Write-first forwarding for the operand ports only. Gated by rst_n
        // so outputs stay zero throughout reset.
        if (rst_n && wr_hit && (ra1 == wa)) begin
            rd1 = wd;
        end
        if (rst_n && wr_hit && (ra2 == wa)) begin
            rd2 = wd;
        end
`endif
    end

endmodule
